vita_stream_gen: RTL and testbench

//  Sensor-side emulator for the VITA capture path. Reads stored frames from a 64-bit frame buffer and serialises them onto
//  the 1-bit sync lane and 4-bit data lane, using the same word framing the capture chain decodes (FS/FE/LS/LE/IMG/ID/TR).

---
 rtl/vita_sync_pkg.sv | 40 ++++
 rtl/vita_word_ser.sv | 53 +++++
 rtl/vita_stream_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_vita_stream_gen.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vita_sync_pkg.sv
// Shared word-framing definitions for the VITA serial lanes.
// Holds the sync-code width, the 16-bit sync codes for every word type,
// the word-type enum, and a helper that maps a word type to its sync code.
// The capture-side sync decoder imports the same package, so both ends
// always agree on the framing.
package vita_sync_pkg;

  localparam int SYNC_W = 16;

  localparam logic [SYNC_W-1:0] CODE_FS  = 16'hAA01;
  localparam logic [SYNC_W-1:0] CODE_FE  = 16'hAA02;
  localparam logic [SYNC_W-1:0] CODE_LS  = 16'hAA04;
  localparam logic [SYNC_W-1:0] CODE_LE  = 16'hAA08;
  localparam logic [SYNC_W-1:0] CODE_IMG = 16'hAA10;
  localparam logic [SYNC_W-1:0] CODE_ID  = 16'hAA20;
  localparam logic [SYNC_W-1:0] CODE_TR  = 16'h5555;

  typedef enum logic [2:0] {
    WT_TR  = 3'd0,
    WT_FS  = 3'd1,
    WT_FE  = 3'd2,
    WT_LS  = 3'd3,
    WT_LE  = 3'd4,
    WT_IMG = 3'd5,
    WT_ID  = 3'd6
  } word_t;

  function automatic logic [SYNC_W-1:0] sync_code(input word_t wt);
    case (wt)
      WT_FS:   sync_code = CODE_FS;
      WT_FE:   sync_code = CODE_FE;
      WT_LS:   sync_code = CODE_LS;
      WT_LE:   sync_code = CODE_LE;
      WT_IMG:  sync_code = CODE_IMG;
      WT_ID:   sync_code = CODE_ID;
      default: sync_code = CODE_TR;
    endcase
  endfunction

endpackage

// File: rtl/vita_word_ser.sv
// Word serialiser for the VITA lanes.
// Loads a {sync code, 64-bit word} pair on the cycle that becomes nib 0 of a
// word period, then shifts out one sync bit (MSB first) and one data nibble
// ([63:60] first) per pclock for 16 cycles.
// Ports:
//   pclock  in   clock, rising edge
//   reset   in   synchronous active-high reset
//   load    in   take code/word on this edge (next cycle shows their MSBs)
//   code    in   16-bit sync code of the next word
//   word    in   64-bit payload of the next word
//   sync    out  sync lane bit (register bit)
//   data    out  data lane nibble (register bits)
module vita_word_ser
  import vita_sync_pkg::*;
(
  input  logic              pclock,
  input  logic              reset,
  input  logic              load,
  input  logic [SYNC_W-1:0] code,
  input  logic [63:0]       word,
  output logic              sync,
  output logic [3:0]        data
);

  logic [SYNC_W-1:0] code_q, code_d;
  logic [63:0]       word_q, word_d;

  always_comb begin
    if (load) begin
      code_d = code;
      word_d = word;
    end else begin
      code_d = {code_q[SYNC_W-2:0], 1'b0};
      word_d = {word_q[59:0], 4'h0};
    end
  end

  // Reset leaves a TR word at nib 0 on the lanes; TR's MSB is 0, so the
  // lanes read 0 immediately after reset and the idle stream continues.
  always_ff @(posedge pclock) begin
    if (reset) begin
      code_q <= CODE_TR;
      word_q <= '0;
    end else begin
      code_q <= code_d;
      word_q <= word_d;
    end
  end

  assign sync = code_q[SYNC_W-1];
  assign data = word_q[63:60];

endmodule

// File: rtl/vita_stream_gen.sv
// VITA stream generator: sensor-side emulator for the capture path.
// Reads stored frames from a 64-bit frame buffer and serialises them as
// START, ID, IMG x WORDS_PER_LINE, END, TR x HBLANK_WORDS per line, followed
// by VBLANK_LINES all-TR lines. One word period is 16 pclocks.
// Ports:
//   pclock      in   pixel clock
//   reset       in   synchronous active-high reset
//   enable      in   frame request, sampled only at frame boundaries
//   base_addr   in   buffer address of pixel word 0, latched at frame start
//   r_addr      out  frame buffer read address
//   r_en        out  read strobe, r_data valid the following cycle
//   r_data      in   frame buffer read data
//   sync        out  sync lane
//   data        out  data lane
//   busy        out  high from first FS cycle through last VBLANK cycle
//   frame_done  out  pulse on the last cycle of the final VBLANK word
module vita_stream_gen
  import vita_sync_pkg::*;
#(
  parameter int WORDS_PER_LINE = 240,
  parameter int NUM_LINES      = 1080,
  parameter int HBLANK_WORDS   = 4,
  parameter int VBLANK_LINES   = 2
) (
  input  logic        pclock,
  input  logic        reset,
  input  logic        enable,
  input  logic [18:0] base_addr,
  output logic [18:0] r_addr,
  output logic        r_en,
  input  logic [63:0] r_data,
  output logic        sync,
  output logic [3:0]  data,
  output logic        busy,
  output logic        frame_done
);

  localparam int LINE_LEN = WORDS_PER_LINE + 3 + HBLANK_WORDS;
  localparam int WC_W     = ($clog2(LINE_LEN) < 1) ? 1 : $clog2(LINE_LEN);
  localparam int LC_W     = ($clog2(NUM_LINES + VBLANK_LINES) < 1) ? 1
                                                                   : $clog2(NUM_LINES + VBLANK_LINES);

  localparam logic [WC_W-1:0] PIX_LAST = WC_W'(WORDS_PER_LINE - 1);
  localparam logic [WC_W-1:0] HB_LAST  = WC_W'(HBLANK_WORDS - 1);
  localparam logic [WC_W-1:0] LL_LAST  = WC_W'(LINE_LEN - 1);
  localparam logic [LC_W-1:0] IMG_LAST_LINE   = LC_W'(NUM_LINES - 1);
  localparam logic [LC_W-1:0] FRAME_LAST_LINE = LC_W'(NUM_LINES + VBLANK_LINES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_ID     = 3'd2;
  localparam logic [2:0] ST_PIX    = 3'd3;
  localparam logic [2:0] ST_END    = 3'd4;
  localparam logic [2:0] ST_HBLANK = 3'd5;
  localparam logic [2:0] ST_VBLANK = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [3:0]      nib_q, nib_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [LC_W-1:0] line_q, line_d;
  logic [18:0]     addr_q, addr_d;       // address of the next read
  logic [18:0]     r_addr_q, r_addr_d;
  logic            r_en_q, r_en_d;
  logic            rd_dly_q, rd_dly_d;   // r_data is valid while this is high
  logic [63:0]     prefetch_q, prefetch_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;

  logic              start_frame;
  logic              ser_load;
  word_t             ld_type;
  logic [63:0]       ld_word;
  logic [SYNC_W-1:0] ld_code;

  always_comb begin
    state_d      = state_q;
    nib_d        = nib_q + 4'd1;
    wcnt_d       = wcnt_q;
    line_d       = line_q;
    addr_d       = addr_q;
    r_addr_d     = r_addr_q;
    r_en_d       = 1'b0;
    rd_dly_d     = r_en_q;
    prefetch_d   = prefetch_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    start_frame  = 1'b0;
    ser_load     = 1'b0;
    ld_type      = WT_TR;
    ld_word      = '0;

    if (rd_dly_q) prefetch_d = r_data;

    // Registered, so raise it one cycle early to land on nib 15.
    if (state_q == ST_VBLANK && wcnt_q == LL_LAST && line_q == FRAME_LAST_LINE &&
        nib_q == 4'd14)
      frame_done_d = 1'b1;

    if (nib_q == 4'd15) begin
      ser_load = 1'b1;
      case (state_q)
        ST_IDLE:  if (enable) start_frame = 1'b1;
        ST_START: state_d = ST_ID;
        ST_ID: begin
          state_d = ST_PIX;
          wcnt_d  = '0;
        end
        ST_PIX: begin
          if (wcnt_q == PIX_LAST) state_d = ST_END;
          else                    wcnt_d  = wcnt_q + WC_W'(1);
        end
        ST_END: begin
          state_d = ST_HBLANK;
          wcnt_d  = '0;
        end
        ST_HBLANK: begin
          if (wcnt_q == HB_LAST) begin
            wcnt_d  = '0;
            line_d  = line_q + LC_W'(1);
            state_d = (line_q == IMG_LAST_LINE) ? ST_VBLANK : ST_START;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
        ST_VBLANK: begin
          if (wcnt_q == LL_LAST) begin
            wcnt_d = '0;
            // The line counter keeps counting through the blanking lines.
            if (line_q == FRAME_LAST_LINE) begin
              if (enable) start_frame = 1'b1;
              else        state_d     = ST_IDLE;
            end else begin
              line_d = line_q + LC_W'(1);
            end
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (start_frame) begin
        state_d = ST_START;
        line_d  = '0;
        wcnt_d  = '0;
        addr_d  = base_addr;
      end

      busy_d = (state_d != ST_IDLE);

      case (state_d)
        ST_START: ld_type = (line_d == '0) ? WT_FS : WT_LS;
        ST_ID: begin
          ld_type = WT_ID;
          ld_word = 64'(line_d);
        end
        ST_PIX: begin
          ld_type = WT_IMG;
          ld_word = prefetch_q;
        end
        ST_END:  ld_type = (line_d == IMG_LAST_LINE) ? WT_FE : WT_LE;
        default: ld_type = WT_TR;
      endcase

      // Each read prefetches the next IMG word, so the last IMG word of a
      // line issues none and the ID word issues the first.
      if (state_d == ST_ID || (state_d == ST_PIX && wcnt_d != PIX_LAST)) begin
        r_en_d   = 1'b1;
        r_addr_d = addr_q;
        addr_d   = addr_q + 19'd1;
      end
    end
  end

  always_ff @(posedge pclock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      nib_q        <= '0;
      wcnt_q       <= '0;
      line_q       <= '0;
      addr_q       <= '0;
      r_addr_q     <= '0;
      r_en_q       <= 1'b0;
      rd_dly_q     <= 1'b0;
      prefetch_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      nib_q        <= nib_d;
      wcnt_q       <= wcnt_d;
      line_q       <= line_d;
      addr_q       <= addr_d;
      r_addr_q     <= r_addr_d;
      r_en_q       <= r_en_d;
      rd_dly_q     <= rd_dly_d;
      prefetch_q   <= prefetch_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ld_code = sync_code(ld_type);

  vita_word_ser u_ser (
    .pclock (pclock),
    .reset  (reset),
    .load   (ser_load),
    .code   (ld_code),
    .word   (ld_word),
    .sync   (sync),
    .data   (data)
  );

  assign r_addr     = r_addr_q;
  assign r_en       = r_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vita_stream_gen.sv
module tb_vita_stream_gen;

  localparam int W  = 2;
  localparam int N  = 2;
  localparam int H  = 1;
  localparam int V  = 1;
  localparam int LL = W + 3 + H;

  localparam logic [15:0] C_FS  = 16'hAA01;
  localparam logic [15:0] C_FE  = 16'hAA02;
  localparam logic [15:0] C_LS  = 16'hAA04;
  localparam logic [15:0] C_LE  = 16'hAA08;
  localparam logic [15:0] C_IMG = 16'hAA10;
  localparam logic [15:0] C_ID  = 16'hAA20;
  localparam logic [15:0] C_TR  = 16'h5555;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [18:0] base_addr = '0;
  logic [18:0] r_addr;
  logic        r_en;
  logic [63:0] r_data = '0;
  logic        sync;
  logic [3:0]  data;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  vita_stream_gen #(
    .WORDS_PER_LINE (W),
    .NUM_LINES      (N),
    .HBLANK_WORDS   (H),
    .VBLANK_LINES   (V)
  ) dut (
    .pclock     (clk),
    .reset      (reset),
    .enable     (enable),
    .base_addr  (base_addr),
    .r_addr     (r_addr),
    .r_en       (r_en),
    .r_data     (r_data),
    .sync       (sync),
    .data       (data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_on = 1'b0;
  logic [31:0] mem_key = '0;

  function automatic logic [63:0] mem_word(input logic [18:0] a);
    return {16{a[3:0]}} ^ {mem_key, mem_key};
  endfunction

  // Frame buffer: data valid one cycle after r_en, garbage otherwise.
  always @(posedge clk) r_data <= r_en ? mem_word(r_addr) : {$urandom, $urandom};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- word-level reference model ----------------
  typedef struct {
    logic [15:0] code;
    logic [63:0] data;
    bit          rd;
    logic [18:0] addr;
    bit          inf;
    bit          last;
  } wrd_t;

  wrd_t mq[$];
  wrd_t cur;
  int   m_nib;

  function automatic wrd_t mk(input logic [15:0] c, input logic [63:0] d, input bit rd,
                              input logic [18:0] a, input bit inf);
    wrd_t t;
    t.code = c; t.data = d; t.rd = rd; t.addr = a; t.inf = inf; t.last = 1'b0;
    return t;
  endfunction

  task automatic build_frame(input logic [18:0] base);
    logic [18:0] a;
    wrd_t t;
    a = base;
    for (int l = 0; l < N; l++) begin
      mq.push_back(mk((l == 0) ? C_FS : C_LS, 64'h0, 1'b0, 19'h0, 1'b1));
      mq.push_back(mk(C_ID, 64'(l), 1'b1, a, 1'b1));
      for (int k = 0; k < W; k++)
        mq.push_back(mk(C_IMG, mem_word(a + 19'(k)), k < W - 1, a + 19'(k + 1), 1'b1));
      a = a + 19'(W);
      mq.push_back(mk((l == N - 1) ? C_FE : C_LE, 64'h0, 1'b0, 19'h0, 1'b1));
      for (int h = 0; h < H; h++) mq.push_back(mk(C_TR, 64'h0, 1'b0, 19'h0, 1'b1));
    end
    for (int v = 0; v < V * LL; v++) mq.push_back(mk(C_TR, 64'h0, 1'b0, 19'h0, 1'b1));
    t = mq.pop_back();
    t.last = 1'b1;
    mq.push_back(t);
  endtask

  // Model advances on the same edges as the DUT; it describes what the
  // outputs show after each edge.
  initial begin
    m_nib = 0;
    cur = mk(C_TR, 64'h0, 1'b0, 19'h0, 1'b0);
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        cur = mk(C_TR, 64'h0, 1'b0, 19'h0, 1'b0);
        m_nib = 0;
      end else if (m_nib == 15) begin
        m_nib = 0;
        if (mq.size() == 0 && enable) build_frame(base_addr);
        if (mq.size() != 0) cur = mq.pop_front();
        else                cur = mk(C_TR, 64'h0, 1'b0, 19'h0, 1'b0);
      end else begin
        m_nib = m_nib + 1;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    logic exp_ren;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        exp_ren = cur.rd && (m_nib == 0);
        chk("sync", 64'(sync), 64'(cur.code[15 - m_nib]));
        chk("data", 64'(data), 64'(cur.data[63 - 4 * m_nib -: 4]));
        chk("r_en", 64'(r_en), 64'(exp_ren));
        if (exp_ren) chk("r_addr", 64'(r_addr), 64'(cur.addr));
        chk("busy", 64'(busy), 64'(cur.inf));
        chk("frame_done", 64'(frame_done), 64'(cur.last && m_nib == 15));
      end
    end
  end

  // ---------------- pin-level capture for literal checks ----------------
  logic [15:0] cc[40];
  logic [63:0] cw[40];
  logic [18:0] ca[16];
  int          n_rd, fd_cycle, fd_cnt;

  task automatic collect(input int nwords, input int drop_c);
    int waited;
    int w;
    waited = 0; n_rd = 0; fd_cycle = -1; fd_cnt = 0;
    while (busy !== 1'b1) begin
      if (waited == 200) begin
        n_cmp++; n_bad++;
        $display("FAIL busy_rise_timeout: busy still %b after %0d cycles, required 1", busy, waited);
        return;
      end
      @(negedge clk);
      waited++;
    end
    for (int c = 0; c < nwords * 16; c++) begin
      if (c == drop_c) enable = 1'b0;
      w = c / 16;
      cc[w] = {cc[w][14:0], sync};
      cw[w] = {cw[w][59:0], data};
      if (r_en === 1'b1) begin
        if (n_rd < 16) ca[n_rd] = r_addr;
        n_rd++;
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        fd_cycle = c;
      end
      @(negedge clk);
    end
  endtask

  logic [15:0] exp_codes[18];
  logic [63:0] sacc;
  logic        seen_ren, seen_busy;
  logic [18:0] b;
  int          fd_a;

  initial begin
    exp_codes = '{C_FS, C_ID, C_IMG, C_IMG, C_LE, C_TR, C_LS, C_ID, C_IMG, C_IMG, C_FE, C_TR,
                  C_TR, C_TR, C_TR, C_TR, C_TR, C_TR};

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_sync", 64'(sync), 64'h0);
    chk("rst_data", 64'(data), 64'h0);
    chk("rst_r_en", 64'(r_en), 64'h0);
    chk("rst_r_addr", 64'(r_addr), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_frame_done", 64'(frame_done), 64'h0);
    reset = 1'b0;

    // 1: idle stream
    sacc = '0; seen_ren = 1'b0; seen_busy = 1'b0;
    for (int i = 0; i < 64; i++) begin
      sacc = {sacc[62:0], sync};
      seen_ren  = seen_ren | r_en;
      seen_busy = seen_busy | busy;
      @(negedge clk);
    end
    chk("idle_sync_bits", sacc, 64'h5555_5555_5555_5555);
    chk("idle_r_en_seen", 64'(seen_ren), 64'h0);
    chk("idle_busy_seen", 64'(seen_busy), 64'h0);

    // 2: single frame, base 0x100, mem[a] = {16{a[3:0]}}
    mem_key = '0;
    base_addr = 19'h100;
    enable = 1'b1;
    collect(18, 0);
    for (int i = 0; i < 18; i++) chk($sformatf("t2_code%0d", i), 64'(cc[i]), 64'(exp_codes[i]));
    chk("t2_id0", cw[1], 64'h0);
    chk("t2_id1", cw[7], 64'h1);
    chk("t2_img0", cw[2], 64'h0000_0000_0000_0000);
    chk("t2_img1", cw[3], 64'h1111_1111_1111_1111);
    chk("t2_img2", cw[8], 64'h2222_2222_2222_2222);
    chk("t2_img3", cw[9], 64'h3333_3333_3333_3333);
    chk("t2_n_rd", 64'(n_rd), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_addr%0d", i), 64'(ca[i]), 64'h100 + 64'(i));
    chk("t2_fd_cycle", 64'(fd_cycle), 64'd287);
    chk("t2_fd_cnt", 64'(fd_cnt), 64'd1);
    repeat (40) @(negedge clk);

    // 3: address wrap
    mem_key = $urandom;
    base_addr = 19'h7FFFE;
    enable = 1'b1;
    collect(18, 0);
    chk("t3_addr0", 64'(ca[0]), 64'h7FFFE);
    chk("t3_addr1", 64'(ca[1]), 64'h7FFFF);
    chk("t3_addr2", 64'(ca[2]), 64'h00000);
    chk("t3_addr3", 64'(ca[3]), 64'h00001);
    chk("t3_img0", cw[2], mem_word(19'h7FFFE));
    chk("t3_img3", cw[9], mem_word(19'h00001));
    repeat (20) @(negedge clk);

    // 4: enable dropped during line 0 IMG
    base_addr = 19'($urandom);
    enable = 1'b1;
    collect(18, 40);
    chk("t4_fd_cnt", 64'(fd_cnt), 64'd1);
    chk("t4_fd_cycle", 64'(fd_cycle), 64'd287);
    chk("t4_n_rd", 64'(n_rd), 64'd4);
    seen_ren = 1'b0; seen_busy = 1'b0;
    for (int i = 0; i < 64; i++) begin
      seen_ren  = seen_ren | r_en;
      seen_busy = seen_busy | busy;
      @(negedge clk);
    end
    chk("t4_after_r_en", 64'(seen_ren), 64'h0);
    chk("t4_after_busy", 64'(seen_busy), 64'h0);

    // 5: reset during an IMG word
    base_addr = 19'($urandom);
    enable = 1'b1;
    collect(3, -1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_sync", 64'(sync), 64'h0);
    chk("t5_data", 64'(data), 64'h0);
    chk("t5_r_en", 64'(r_en), 64'h0);
    chk("t5_r_addr", 64'(r_addr), 64'h0);
    chk("t5_busy", 64'(busy), 64'h0);
    chk("t5_frame_done", 64'(frame_done), 64'h0);
    reset = 1'b0;
    b = 19'($urandom);
    base_addr = b;
    collect(18, 0);
    chk("t5_code0", 64'(cc[0]), 64'(C_FS));
    chk("t5_addr0", 64'(ca[0]), 64'(b));
    repeat (20) @(negedge clk);

    // 6: back-to-back frames, ID contents
    b = 19'($urandom);
    base_addr = b;
    enable = 1'b1;
    collect(18, -1);
    fd_a = fd_cycle;
    chk("t6_id0", cw[1], 64'h0);
    chk("t6_id1", cw[7], 64'h1);
    collect(18, -1);
    chk("t6_fd_a", 64'(fd_a), 64'd287);
    chk("t6_b2b_code0", 64'(cc[0]), 64'(C_FS));
    chk("t6_b2b_addr0", 64'(ca[0]), 64'(b));
    enable = 1'b0;
    repeat (300) @(negedge clk);

    // Random enable / base / reset activity, checked by the model
    for (int it = 0; it < 40; it++) begin
      enable = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) base_addr = 19'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      repeat ($urandom_range(1, 150)) @(negedge clk);
    end
    enable = 1'b0;
    repeat (320) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
